// File: rtl/minterm_sweep_checker.sv
// Sweeps every minterm into an external SOP/POS gate pair, captures both truth tables and
// compares them against an expected truth table, reporting mismatch count and first failure.
module minterm_sweep_checker #(
  parameter int unsigned N_VARS = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [2**N_VARS-1:0]   expect_tt_i,
  output logic [N_VARS-1:0]      vec_o,
  input  logic                   sop_in_i,
  input  logic                   pos_in_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   results_valid_o,
  output logic [2**N_VARS-1:0]   sop_tt_o,
  output logic [2**N_VARS-1:0]   pos_tt_o,
  output logic [N_VARS:0]        mismatch_cnt_o,
  output logic [N_VARS-1:0]      first_fail_idx_o,
  output logic                   pass_o
);

  localparam int unsigned NMin = 2**N_VARS;
  localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDrive  = 2'd1;
  localparam logic [1:0] StSample = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [N_VARS-1:0] idx_q, idx_d;
  logic [SetW-1:0]   settle_q, settle_d;
  logic [NMin-1:0]   exp_q, exp_d;
  logic [NMin-1:0]   sop_tt_q, sop_tt_d;
  logic [NMin-1:0]   pos_tt_q, pos_tt_d;
  logic [N_VARS:0]   cnt_q, cnt_d;
  logic [N_VARS-1:0] ffi_q, ffi_d;
  logic              rv_q, rv_d;
  logic              fail;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    exp_d    = exp_q;
    sop_tt_d = sop_tt_q;
    pos_tt_d = pos_tt_q;
    cnt_d    = cnt_q;
    ffi_d    = ffi_q;
    rv_d     = rv_q;
    fail     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          exp_d    = expect_tt_i;
          sop_tt_d = '0;
          pos_tt_d = '0;
          cnt_d    = '0;
          ffi_d    = '0;
          rv_d     = 1'b0;
          idx_d    = '0;
          settle_d = '0;
          state_d  = StDrive;
        end
      end
      StDrive: begin
        if (settle_q == SetW'(SETTLE - 1)) begin
          settle_d = '0;
          state_d  = StSample;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StSample: begin
        sop_tt_d[idx_q] = sop_in_i;
        pos_tt_d[idx_q] = pos_in_i;
        // Case inequality so X/Z from the gate is reported as a failure.
        fail = (sop_in_i !== exp_q[idx_q]) || (pos_in_i !== exp_q[idx_q]);
        if (fail) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '0) ffi_d = idx_q;
        end
        if (idx_q == {N_VARS{1'b1}}) begin
          rv_d    = 1'b1;
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StDrive;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      settle_q <= '0;
      exp_q    <= '0;
      sop_tt_q <= '0;
      pos_tt_q <= '0;
      cnt_q    <= '0;
      ffi_q    <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      exp_q    <= exp_d;
      sop_tt_q <= sop_tt_d;
      pos_tt_q <= pos_tt_d;
      cnt_q    <= cnt_d;
      ffi_q    <= ffi_d;
      rv_q     <= rv_d;
    end
  end

  assign busy_o           = (state_q == StDrive) || (state_q == StSample);
  assign vec_o            = busy_o ? idx_q : '0;
  assign done_o           = (state_q == StDone);
  assign results_valid_o  = rv_q;
  assign sop_tt_o         = sop_tt_q;
  assign pos_tt_o         = pos_tt_q;
  assign mismatch_cnt_o   = cnt_q;
  assign first_fail_idx_o = ffi_q;
  assign pass_o           = rv_q && (cnt_q == '0);

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Bench for minterm_sweep_checker: a behavioural gate model feeds the DUT, and a scoreboard of
// expected sweep results is compared when done pulses.
module tb_minterm_sweep_checker;

  typedef struct {
    logic [15:0] sop;
    logic [15:0] pos;
    logic [4:0]  cnt;
    logic [3:0]  ffi;
    logic        pass;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [15:0] expect_tt = '0;
  int          gmode = 0;
  logic        gflip = 1'b0;

  logic        start1, start3;
  logic [3:0]  vec1, vec3;
  logic        sop1, pos1, sop3, pos3;
  logic        busy1, done1, rv1, pass1, busy3, done3, rv3, pass3;
  logic [15:0] sopt1, post1, sopt3, post3;
  logic [4:0]  cnt1, cnt3;
  logic [3:0]  ffi1, ffi3;

  logic [3:0]  vec_s, ffi_s;
  logic        busy_s, done_s, rv_s, pass_s;
  logic [15:0] sop_s, pos_s;
  logic [4:0]  cnt_s;

  always #5 clk = ~clk;

  assign start1 = start && !sel;
  assign start3 = start && sel;

  function automatic logic gate(input int mode, input logic [3:0] m);
    case (mode)
      0:       return ~m[0];
      1:       return m[1] ~^ m[0];
      default: return m[3] | (m[2] & m[0]) | (m[2] & m[1]);
    endcase
  endfunction

  always_comb begin
    sop1 = gate(gmode, vec1);
    pos1 = (gflip && vec1 == 4'd6) ? ~sop1 : sop1;
    sop3 = gate(gmode, vec3);
    pos3 = (gflip && vec3 == 4'd6) ? ~sop3 : sop3;
  end

  always_comb begin
    vec_s  = sel ? vec3  : vec1;
    busy_s = sel ? busy3 : busy1;
    done_s = sel ? done3 : done1;
    rv_s   = sel ? rv3   : rv1;
    pass_s = sel ? pass3 : pass1;
    sop_s  = sel ? sopt3 : sopt1;
    pos_s  = sel ? post3 : post1;
    cnt_s  = sel ? cnt3  : cnt1;
    ffi_s  = sel ? ffi3  : ffi1;
  end

  minterm_sweep_checker #(.N_VARS(4), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start_i(start1), .expect_tt_i(expect_tt), .vec_o(vec1),
    .sop_in_i(sop1), .pos_in_i(pos1), .busy_o(busy1), .done_o(done1),
    .results_valid_o(rv1), .sop_tt_o(sopt1), .pos_tt_o(post1), .mismatch_cnt_o(cnt1),
    .first_fail_idx_o(ffi1), .pass_o(pass1)
  );

  minterm_sweep_checker #(.N_VARS(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start_i(start3), .expect_tt_i(expect_tt), .vec_o(vec3),
    .sop_in_i(sop3), .pos_in_i(pos3), .busy_o(busy3), .done_o(done3),
    .results_valid_o(rv3), .sop_tt_o(sopt3), .pos_tt_o(post3), .mismatch_cnt_o(cnt3),
    .first_fail_idx_o(ffi3), .pass_o(pass3)
  );

  function automatic exp_t model(input int mode, input logic flip, input logic [15:0] ett,
                                 input int settle);
    exp_t e;
    e.sop = '0; e.pos = '0; e.cnt = '0; e.ffi = '0;
    for (int m = 0; m < 16; m++) begin
      logic s, p;
      s = gate(mode, 4'(m));
      p = (flip && m == 6) ? ~s : s;
      e.sop[m] = s;
      e.pos[m] = p;
      if (s != ett[m] || p != ett[m]) begin
        if (e.cnt == 0) e.ffi = 4'(m);
        e.cnt = e.cnt + 5'd1;
      end
    end
    e.pass = (e.cnt == 0);
    e.cyc  = 16 * (settle + 1) + 1;
    return e;
  endfunction

  task automatic run_sweep(input logic use3, input int mode, input logic flip,
                           input logic [15:0] ett, input logic disturb, input logic chk_vec,
                           input string name);
    exp_t e;
    int   s;
    logic seen;
    s = use3 ? 3 : 1;
    sel = use3; gmode = mode; gflip = flip;
    sb.push_back(model(mode, flip, ett, s));
    @(negedge clk);
    expect_tt = ett;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 16 * (s + 1) + 9 && !seen; c++) begin
      @(negedge clk);
      if (disturb) begin
        start = (c == 5 || c == 20);
        if (c == 5) expect_tt = ~ett;
      end
      if (c == 1) begin
        checks++;
        if (rv_s !== 1'b0) begin
          errors++; $display("FAIL %s rv_cleared got %b want 0", name, rv_s);
        end
      end
      if (chk_vec && c <= 16 * (s + 1)) begin
        checks++;
        if (vec_s !== 4'((c - 1) / (s + 1))) begin
          errors++; $display("FAIL %s vec c%0d got %0d want %0d", name, c, vec_s, (c - 1) / (s + 1));
        end
      end
      if (done_s === 1'b1) begin
        seen = 1'b1;
        e = sb.pop_front();
        checks += 7;
        if (c != e.cyc) begin
          errors++; $display("FAIL %s done_cycle got %0d want %0d", name, c, e.cyc);
        end
        if (sop_s !== e.sop) begin
          errors++; $display("FAIL %s sop_tt got %h want %h", name, sop_s, e.sop);
        end
        if (pos_s !== e.pos) begin
          errors++; $display("FAIL %s pos_tt got %h want %h", name, pos_s, e.pos);
        end
        if (cnt_s !== e.cnt) begin
          errors++; $display("FAIL %s cnt got %0d want %0d", name, cnt_s, e.cnt);
        end
        if (ffi_s !== e.ffi) begin
          errors++; $display("FAIL %s first_fail got %0d want %0d", name, ffi_s, e.ffi);
        end
        if (pass_s !== e.pass) begin
          errors++; $display("FAIL %s pass got %b want %b", name, pass_s, e.pass);
        end
        if (rv_s !== 1'b1) begin
          errors++; $display("FAIL %s results_valid got %b want 1", name, rv_s);
        end
      end
    end
    start = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s done_timeout got none want cycle %0d", name, 16 * (s + 1) + 1);
      void'(sb.pop_front());
    end
    @(negedge clk);
    checks++;
    if (done_s !== 1'b0 || busy_s !== 1'b0 || rv_s !== 1'b1) begin
      errors++;
      $display("FAIL %s after_done got done=%b busy=%b rv=%b want 0 0 1", name, done_s, busy_s, rv_s);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({vec1, busy1, done1, rv1, sopt1, post1, cnt1, ffi1, pass1, vec3, busy3, done3, rv3} !== '0) begin
      errors++; $display("FAIL reset outputs got nonzero want 0");
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_not_d();
    run_sweep(1'b0, 0, 1'b0, 16'h5555, 1'b0, 1'b0, "not_d");
    checks++;
    if (sop_s !== 16'h5555 || pos_s !== 16'h5555 || pass_s !== 1'b1) begin
      errors++; $display("FAIL not_d_lit got %h %h %b want 5555 5555 1", sop_s, pos_s, pass_s);
    end
  endtask

  task automatic test_xnor_vec();
    run_sweep(1'b0, 1, 1'b0, 16'h9999, 1'b0, 1'b1, "xnor");
    checks++;
    if (sop_s !== 16'h9999) begin
      errors++; $display("FAIL xnor_lit got %h want 9999", sop_s);
    end
  endtask

  task automatic test_sop_pos_flip();
    run_sweep(1'b0, 2, 1'b0, 16'hFFE0, 1'b0, 1'b0, "aorbd");
    run_sweep(1'b0, 2, 1'b1, 16'hFFE0, 1'b0, 1'b0, "pos_flip6");
    checks++;
    if (pos_s !== 16'hFFA0 || cnt_s !== 5'd1 || ffi_s !== 4'd6 || pass_s !== 1'b0) begin
      errors++;
      $display("FAIL pos_flip_lit got %h %0d %0d %b want FFA0 1 6 0", pos_s, cnt_s, ffi_s, pass_s);
    end
    gflip = 1'b0;
  endtask

  task automatic test_expect_errors();
    run_sweep(1'b0, 0, 1'b0, 16'h5554, 1'b0, 1'b0, "exp5554");
    run_sweep(1'b0, 0, 1'b0, 16'hAAAA, 1'b0, 1'b0, "expAAAA");
    checks++;
    if (cnt_s !== 5'd16 || ffi_s !== 4'd0 || pass_s !== 1'b0) begin
      errors++; $display("FAIL all_fail_lit got %0d %0d %b want 16 0 0", cnt_s, ffi_s, pass_s);
    end
  endtask

  task automatic test_start_ignored();
    run_sweep(1'b0, 0, 1'b0, 16'h5555, 1'b1, 1'b0, "restart_ignored");
  endtask

  task automatic test_reset_mid_sweep();
    logic seen;
    sel = 1'b0; gmode = 0;
    @(negedge clk);
    expect_tt = 16'h5555;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({vec1, busy1, done1, rv1, sopt1, post1, cnt1, ffi1, pass1} !== '0) begin
      errors++;
      $display("FAIL mid_reset got vec=%0d busy=%b sop=%h want all 0", vec1, busy1, sopt1);
    end
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done1 === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL mid_reset_no_done got done pulse want none");
    end
    run_sweep(1'b0, 0, 1'b0, 16'h5555, 1'b0, 1'b0, "after_reset");
    run_sweep(1'b1, 0, 1'b0, 16'h5555, 1'b0, 1'b1, "settle3");
  endtask

  initial begin
    test_reset();
    test_not_d();
    test_xnor_vec();
    test_sop_pos_flip();
    test_expect_errors();
    test_start_ignored();
    test_reset_mid_sweep();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
